// File: rtl/iob_native_mem_responder.sv
// IOb native bus responder backed by a word-organised RAM.
// Byte-strobed writes, fixed-latency reads and optional wait states
// after every accepted request.

module iob_native_mem_responder #(
   parameter int unsigned ADDR_W      = 32,
   parameter int unsigned DATA_W      = 32,
   parameter int unsigned MEM_ADDR_W  = 10,
   parameter int unsigned READ_LAT    = 1,
   parameter int unsigned WAIT_STATES = 0
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                req_valid,
   input  logic [ADDR_W-1:0]   req_addr,
   input  logic [DATA_W-1:0]   req_wdata,
   input  logic [DATA_W/8-1:0] req_wstrb,
   output logic                resp_ready,
   output logic                resp_rvalid,
   output logic [DATA_W-1:0]   resp_rdata
);

   localparam int unsigned STRB_W = DATA_W / 8;
   localparam int unsigned DEPTH  = 2 ** MEM_ADDR_W;

   localparam logic [0:0] StIdle = 1'b0;
   localparam logic [0:0] StWait = 1'b1;

   logic [0:0]            state_q, state_d;
   logic [3:0]            cnt_q, cnt_d;
   logic                  ready_q, ready_d;

   logic                  accept;
   logic                  is_write;
   logic [MEM_ADDR_W-1:0] idx;
   logic                  unused_addr;

   logic [DATA_W-1:0]     mem [DEPTH];

   logic [READ_LAT-1:0]   pipe_v_q;
   logic [DATA_W-1:0]     pipe_d_q [READ_LAT];

   assign accept   = req_valid & ready_q;
   assign is_write = |req_wstrb;
   // Word index wraps modulo the memory depth; byte-lane and upper bits are dropped.
   assign idx      = req_addr[MEM_ADDR_W+1:2];
   assign unused_addr = ^req_addr;

   // Byte-strobed write port; memory contents survive reset.
   always_ff @(posedge clk) begin
      if (accept && is_write) begin
         for (int i = 0; i < STRB_W; i++) begin
            if (req_wstrb[i]) begin
               mem[idx][i*8 +: 8] <= req_wdata[i*8 +: 8];
            end
         end
      end
   end

   // Read pipeline: memory sampled on the accept edge, then shifted READ_LAT-1 more stages.
   // Data stages load only behind a valid token, so the last stage holds between responses.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pipe_v_q <= '0;
         for (int i = 0; i < READ_LAT; i++) begin
            pipe_d_q[i] <= '0;
         end
      end else begin
         pipe_v_q[0] <= accept & ~is_write;
         if (accept && !is_write) begin
            pipe_d_q[0] <= mem[idx];
         end
         for (int i = 1; i < READ_LAT; i++) begin
            pipe_v_q[i] <= pipe_v_q[i-1];
            if (pipe_v_q[i-1]) begin
               pipe_d_q[i] <= pipe_d_q[i-1];
            end
         end
      end
   end

   assign resp_rvalid = pipe_v_q[READ_LAT-1];
   assign resp_rdata  = pipe_d_q[READ_LAT-1];

   // Wait-state next-state logic: ready drops for exactly WAIT_STATES cycles per accept.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      ready_d = ready_q;
      case (state_q)
         StIdle: begin
            ready_d = 1'b1;
            if (accept && (WAIT_STATES != 0)) begin
               state_d = StWait;
               cnt_d   = 4'(WAIT_STATES);
               ready_d = 1'b0;
            end
         end
         StWait: begin
            if (cnt_q == 4'd1) begin
               state_d = StIdle;
               cnt_d   = 4'd0;
               ready_d = 1'b1;
            end else begin
               cnt_d   = cnt_q - 4'd1;
               ready_d = 1'b0;
            end
         end
         default: begin
            state_d = StIdle;
            cnt_d   = 4'd0;
            ready_d = 1'b0;
         end
      endcase
   end

   // Wait-state registers; ready is low in reset and rises on the first edge after release.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= StIdle;
         cnt_q   <= 4'd0;
         ready_q <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         ready_q <= ready_d;
      end
   end

   assign resp_ready = ready_q;

endmodule

// File: tb/tb_iob_native_mem_responder.sv
// Bench for iob_native_mem_responder: several instances with different latency and
// wait-state settings, directed scenarios followed by random traffic, all checked
// every cycle against a timestamp-based reference model.

module tb_iob_native_mem_responder;

   localparam int NI = 6;

   function automatic int rl_of(input int g);
      case (g)
         0:       return 1;
         1:       return 3;
         2:       return 1;
         3:       return 4;
         4:       return 2;
         default: return 3;
      endcase
   endfunction

   function automatic int ws_of(input int g);
      case (g)
         2:       return 2;
         5:       return 3;
         default: return 0;
      endcase
   endfunction

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   logic        req_valid   [NI];
   logic [31:0] req_addr    [NI];
   logic [31:0] req_wdata   [NI];
   logic [3:0]  req_wstrb   [NI];
   logic        resp_ready  [NI];
   logic        resp_rvalid [NI];
   logic [31:0] resp_rdata  [NI];

   for (genvar g = 0; g < NI; g++) begin : g_dut
      iob_native_mem_responder #(
         .ADDR_W      (32),
         .DATA_W      (32),
         .MEM_ADDR_W  (10),
         .READ_LAT    (rl_of(g)),
         .WAIT_STATES (ws_of(g))
      ) u_dut (
         .clk         (clk),
         .rst         (rst),
         .req_valid   (req_valid[g]),
         .req_addr    (req_addr[g]),
         .req_wdata   (req_wdata[g]),
         .req_wstrb   (req_wstrb[g]),
         .resp_ready  (resp_ready[g]),
         .resp_rvalid (resp_rvalid[g]),
         .resp_rdata  (resp_rdata[g])
      );
   end

   // Reference model: word memory, last-accept timestamp for ready, and a calendar of
   // read responses keyed by the edge number at which they must be visible.
   logic [31:0] mdl_mem    [NI][1024];
   int          last_acc   [NI];
   logic        mdl_ready  [NI];
   logic        cal_v      [NI][8];
   logic [31:0] cal_d      [NI][8];
   logic        exp_rvalid [NI];
   logic [31:0] exp_rdata  [NI];
   logic        acc        [NI];
   int          cyc;
   int          rst_edge;
   int          vectors;
   int          miscompares;

   task automatic check(input string tag, input int i, input logic [31:0] obs,
                        input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s inst%0d cyc=%0d got=%h want=%h", tag, i, cyc, obs, exp);
      end
   endtask

   task automatic mdl_clear();
      for (int i = 0; i < NI; i++) begin
         last_acc[i]   = -1000;
         mdl_ready[i]  = 1'b0;
         exp_rvalid[i] = 1'b0;
         exp_rdata[i]  = 32'h0;
         for (int s = 0; s < 8; s++) cal_v[i][s] = 1'b0;
      end
   endtask

   // One clock: decide accepts from model ready, advance model, compare at the negedge.
   task automatic cycle();
      for (int i = 0; i < NI; i++) acc[i] = req_valid[i] && mdl_ready[i];
      @(posedge clk);
      cyc++;
      for (int i = 0; i < NI; i++) begin
         int idx;
         int s;
         idx = int'(req_addr[i][11:2]);
         if (acc[i]) begin
            if (req_wstrb[i] != 4'h0) begin
               for (int b = 0; b < 4; b++)
                  if (req_wstrb[i][b]) mdl_mem[i][idx][b*8 +: 8] = req_wdata[i][b*8 +: 8];
            end else begin
               s = (cyc + rl_of(i) - 1) % 8;
               cal_v[i][s] = 1'b1;
               cal_d[i][s] = mdl_mem[i][idx];
            end
            last_acc[i] = cyc;
         end
         mdl_ready[i]  = (cyc > rst_edge) && (cyc >= last_acc[i] + ws_of(i));
         exp_rvalid[i] = cal_v[i][cyc % 8];
         if (cal_v[i][cyc % 8]) exp_rdata[i] = cal_d[i][cyc % 8];
         cal_v[i][cyc % 8] = 1'b0;
      end
      @(negedge clk);
      for (int i = 0; i < NI; i++) begin
         check("ready", i, 32'(resp_ready[i]), 32'(mdl_ready[i]));
         check("rvalid", i, 32'(resp_rvalid[i]), 32'(exp_rvalid[i]));
         check("rdata", i, resp_rdata[i], exp_rdata[i]);
      end
   endtask

   task automatic idle(input int i);
      req_valid[i] = 1'b0;
      req_addr[i]  = 32'h0;
      req_wdata[i] = 32'h0;
      req_wstrb[i] = 4'h0;
   endtask

   // Present a request and hold it until accepted (bounded).
   task automatic issue(input int i, input logic [31:0] a, input logic [31:0] d,
                        input logic [3:0] s);
      req_valid[i] = 1'b1;
      req_addr[i]  = a;
      req_wdata[i] = d;
      req_wstrb[i] = s;
      for (int k = 0; k < 40; k++) begin
         cycle();
         if (acc[i]) break;
      end
   endtask

   // Wait (bounded) for the next response of instance i and compare it to a constant.
   task automatic expect_read(input int i, input logic [31:0] exp, input string tag);
      bit          got;
      logic [31:0] d;
      got = 1'b0;
      d   = 32'h0;
      for (int k = 0; k <= 8; k++) begin
         if (resp_rvalid[i]) begin
            got = 1'b1;
            d   = resp_rdata[i];
            break;
         end
         cycle();
      end
      check({tag, "_seen"}, i, 32'(got), 32'd1);
      check(tag, i, d, exp);
   endtask

   initial begin
      int          first;
      int          last;
      int          got;
      int          nacc;
      int          nw;
      logic [6:0]  pat;
      logic [31:0] rd [4];
      bit          was_acc;

      vectors     = 0;
      miscompares = 0;
      cyc         = 0;
      rst_edge    = 1 << 30;
      rst         = 1'b1;
      for (int i = 0; i < NI; i++) idle(i);
      mdl_clear();

      // Reset state, then release.
      cycle();
      cycle();
      rst      = 1'b0;
      rst_edge = cyc;
      cycle();
      check("ready_after_release", 0, 32'(resp_ready[0]), 32'd1);

      // Basic write/read, latency 1.
      issue(0, 32'h10, 32'hDEADBEEF, 4'hF);
      idle(0);
      check("wr_no_rvalid", 0, 32'(resp_rvalid[0]), 32'd0);
      cycle();
      issue(0, 32'h10, 32'h0, 4'h0);
      idle(0);
      expect_read(0, 32'hDEADBEEF, "rd_basic");

      // Byte strobes.
      issue(0, 32'h20, 32'h11223344, 4'hF);
      issue(0, 32'h20, 32'hAABBCCDD, 4'h5);
      issue(0, 32'h20, 32'h0, 4'h0);
      idle(0);
      expect_read(0, 32'h11BB33DD, "rd_strobe");

      // Address wrap.
      issue(0, 32'h1000, 32'h5A5A5A5A, 4'hF);
      issue(0, 32'h0, 32'h0, 4'h0);
      idle(0);
      expect_read(0, 32'h5A5A5A5A, "rd_wrap");

      // Latency 3, four back-to-back reads.
      for (int k = 0; k < 4; k++) issue(1, 32'(k * 4), 32'(k + 1), 4'hF);
      got   = 0;
      first = -1;
      last  = -1;
      for (int k = 0; k < 10; k++) begin
         if (k < 4) begin
            req_valid[1] = 1'b1;
            req_addr[1]  = 32'(k * 4);
            req_wdata[1] = 32'h0;
            req_wstrb[1] = 4'h0;
         end else begin
            idle(1);
         end
         cycle();
         if (resp_rvalid[1]) begin
            if (got < 4) rd[got] = resp_rdata[1];
            if (got == 0) first = k;
            last = k;
            got++;
         end
      end
      check("lat3_count", 1, 32'(got), 32'd4);
      check("lat3_first", 1, 32'(first), 32'd2);
      check("lat3_last", 1, 32'(last), 32'd5);
      for (int k = 0; k < 4; k++) check("lat3_data", 1, rd[k], 32'(k + 1));

      // Two wait states with valid held across three writes.
      pat  = '0;
      nacc = 0;
      nw   = 0;
      for (int k = 0; k < 7; k++) begin
         if (nw < 3) begin
            req_valid[2] = 1'b1;
            req_addr[2]  = 32'h100 + 32'(nw * 4);
            req_wdata[2] = 32'hC0DE0000 + 32'(nw);
            req_wstrb[2] = 4'hF;
         end else begin
            idle(2);
         end
         pat     = {pat[5:0], resp_ready[2]};
         was_acc = resp_ready[2] && req_valid[2];
         cycle();
         if (was_acc) begin
            nacc++;
            nw++;
         end
      end
      idle(2);
      check("ws2_ready_pattern", 2, 32'(pat), 32'b1001001);
      check("ws2_accepts", 2, 32'(nacc), 32'd3);
      for (int k = 0; k < 3; k++) begin
         issue(2, 32'h100 + 32'(k * 4), 32'h0, 4'h0);
         idle(2);
         expect_read(2, 32'hC0DE0000 + 32'(k), "ws2_readback");
      end

      // Reset two cycles after a latency-4 read accept.
      issue(3, 32'h0, 32'h600DF00D, 4'hF);
      issue(3, 32'h0, 32'h0, 4'h0);
      idle(3);
      cycle();
      rst      = 1'b1;
      rst_edge = 1 << 30;
      mdl_clear();
      #1;
      check("rst_ready_async", 3, 32'(resp_ready[3]), 32'd0);
      check("rst_rvalid_async", 3, 32'(resp_rvalid[3]), 32'd0);
      @(negedge clk);
      got = 0;
      for (int k = 0; k < 2; k++) begin
         cycle();
         if (resp_rvalid[3]) got++;
      end
      rst      = 1'b0;
      rst_edge = cyc;
      cycle();
      check("rst_ready_up", 3, 32'(resp_ready[3]), 32'd1);
      for (int k = 0; k < 6; k++) begin
         cycle();
         if (resp_rvalid[3]) got++;
      end
      check("rst_dropped_rvalid", 3, 32'(got), 32'd0);
      issue(3, 32'h0, 32'h0, 4'h0);
      idle(3);
      expect_read(3, 32'h600DF00D, "rst_mem_kept");

      // Read-before-write hazard, latency 2.
      issue(4, 32'h40, 32'h7, 4'hF);
      issue(4, 32'h40, 32'h0, 4'h0);
      issue(4, 32'h40, 32'h9, 4'hF);
      idle(4);
      expect_read(4, 32'h7, "hazard_old");
      issue(4, 32'h40, 32'h0, 4'h0);
      idle(4);
      expect_read(4, 32'h9, "hazard_new");

      // Preload words 0..15 of every instance, then random traffic.
      for (int i = 0; i < NI; i++) begin
         for (int w = 0; w < 16; w++) issue(i, 32'(w * 4), $urandom, 4'hF);
         idle(i);
      end
      for (int i = 0; i < NI; i++) acc[i] = 1'b0;
      for (int n = 0; n < 400; n++) begin
         for (int i = 0; i < NI; i++) begin
            if (!(req_valid[i] && !acc[i])) begin
               req_valid[i] = ($urandom_range(0, 9) < 7);
               req_addr[i]  = ($urandom & 32'hFFFF_F000) | (32'($urandom_range(0, 15)) << 2)
                              | ($urandom & 32'h3);
               req_wdata[i] = $urandom;
               req_wstrb[i] = ($urandom_range(0, 1) == 1) ? 4'($urandom) : 4'h0;
            end
         end
         cycle();
      end
      for (int i = 0; i < NI; i++) idle(i);
      for (int k = 0; k < 8; k++) cycle();

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/iob_native_mem_responder.md
Name: iob_native_mem_responder

Overview:
- Target (responder) end of the IOb native bus, used as on-chip RAM behind a CPU wrapper's ibus/dbus request port.
- Accepts requests with valid/ready and applies byte-strobed writes.
- Returns read data with a fixed, parameterised latency on rvalid/rdata.
- Optional wait-state insertion stresses initiator hold-while-not-ready logic in simulation.

Parameters:
- ADDR_W, 32: bus byte-address width.
- DATA_W, 32: bus data width; byte strobe width DATA_W/8.
- MEM_ADDR_W, 10: log2 of memory depth in words; word index = req_addr[MEM_ADDR_W+1:2].
- READ_LAT, 1: cycles from read acceptance to rvalid, legal range 1..4.
- WAIT_STATES, 0: cycles ready is held low after every accepted request, legal range 0..15.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- req_valid  input  1  request valid.
- req_addr  input  ADDR_W  byte address; bits [1:0] and bits above MEM_ADDR_W+1 are ignored.
- req_wdata  input  DATA_W  write data.
- req_wstrb  input  DATA_W/8  byte write enables; all-zero means read.
- resp_ready  output  1  request accepted this cycle when req_valid&resp_ready.
- resp_rvalid  output  1  one-cycle pulse qualifying resp_rdata.
- resp_rdata  output  DATA_W  read data.

Behaviour:
- Reset (asynchronous):
  - resp_ready=0, resp_rvalid=0, resp_rdata=0.
  - Wait counter=0; read pipeline valid bits cleared.
  - Memory contents are not reset.
- Ready after reset: resp_ready is registered and rises on the first clk edge after rst deasserts.
- Accept: the cycle with req_valid=1 and resp_ready=1. When req_valid=1 and resp_ready=0, the request is ignored; the initiator holds it stable.
- Write (wstrb!=0):
  - On the accept edge, mem[idx] bytes with wstrb[i]=1 are updated; other bytes are unchanged.
  - No rvalid is generated.
- Read (wstrb==0):
  - mem[idx] is sampled on the accept edge.
  - Data travels a READ_LAT-deep valid/data shift pipeline.
  - resp_rvalid=1 for exactly one cycle, READ_LAT cycles after the accept edge. READ_LAT=1 means rvalid is high in the cycle after acceptance.
  - Responses stay in request order.
- Read/write ordering:
  - A read sees all writes accepted before it.
  - A read returns pre-write data for a write accepted after it, even if that write lands before the rvalid.
- resp_rdata:
  - Updates only with resp_rvalid=1.
  - Holds its last value while rvalid=0.
- Wait-state FSM:
  - IDLE: resp_ready=1. On accept with WAIT_STATES>0, go to WAIT with counter=WAIT_STATES and resp_ready=0 from the next cycle.
  - WAIT: resp_ready=0; counter decrements each cycle. When counter==1, resp_ready<=1 and return to IDLE. resp_ready is therefore low for exactly WAIT_STATES cycles.
  - WAIT_STATES=0: the FSM stays in IDLE with resp_ready=1 continuously, giving back-to-back accepts and one rvalid per cycle.
- Throughput: at most one accept per cycle; the pipeline never stalls, so no backpressure on the response side.
- Address wrap: word index is taken modulo 2^MEM_ADDR_W. Example with MEM_ADDR_W=10: 0x1000 aliases 0x0000.
- Reset mid-operation: in-flight reads are dropped, no rvalid is issued for them, and the FSM returns to the post-reset state.
- Writes in flight complete only if their accept edge preceded rst assertion.

Test Plan:
- WAIT_STATES=0, READ_LAT=1:
  - Write 0xDEADBEEF to 0x10 with wstrb=0xF, then read 0x10.
  - Required: rvalid 1 cycle after read accept, rdata=0xDEADBEEF, no rvalid for the write.
- Byte strobes:
  - Write 0x11223344 to 0x20 with wstrb=0xF, then write 0xAABBCCDD with wstrb=0x5, then read 0x20.
  - Required: rdata=0x11BB33DD.
- READ_LAT=3:
  - Read 0x0,0x4,0x8,0xC back-to-back, preloaded with 1,2,3,4.
  - Required: rvalid high 4 consecutive cycles starting 3 cycles after the first accept, data 1,2,3,4 in order.
- WAIT_STATES=2:
  - Hold req_valid=1 for 3 consecutive write requests.
  - Required: resp_ready pattern 1,0,0,1,0,0,1; exactly 3 accepts; final memory matches all 3 writes.
- Reset mid-read (READ_LAT=4):
  - Assert rst 2 cycles after a read accept.
  - Required: no rvalid afterwards, resp_ready=0 during rst and 1 one cycle after release, memory contents preserved.
- Wrap and hazard (MEM_ADDR_W=10):
  - Write 0x5A5A5A5A to 0x1000, then read 0x0000, giving rdata=0x5A5A5A5A.
  - With READ_LAT=2, read 0x40 (old=7) then write 9 next cycle: required rdata=7, and a subsequent read of 0x40 returns 9.
